// File: rtl/jk_pkg.sv
// Shared types and helpers for the JK bank driver.
// Optional build macro: JK_TOGGLE_EN selects the toggle excitation code
// (J=K=1) for changing bits instead of the set/reset encoding.
package jk_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2
    } jk_drv_state_t;

    // JK command codes, packed as {J,K}
    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_RST  = 2'b01;
    localparam logic [1:0] JK_TOG  = 2'b11;

    // Excitation for one bit: current value q, desired value t -> {J,K}
    function automatic logic [1:0] jk_excite(input logic q, input logic t);
        logic [1:0] code;
        code = JK_HOLD;
`ifdef JK_TOGGLE_EN
        if (q != t) code = JK_TOG;
`else
        if (!q && t)      code = JK_SET;
        else if (q && !t) code = JK_RST;
`endif
        return code;
    endfunction

endpackage

// File: rtl/jk_reg_bank.sv
// Behavioural bank of WIDTH JK flip-flops with per-bit freeze.
// A frozen bit ignores its J/K command and holds its value.
module jk_reg_bank
    import jk_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic [WIDTH-1:0] frz,
    output logic [WIDTH-1:0] q
);

    // Per-bit JK update: hold, set, reset or toggle unless frozen
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (!frz[i]) begin
                    case ({j[i], k[i]})
                        JK_SET:  q[i] <= 1'b1;
                        JK_RST:  q[i] <= 1'b0;
                        JK_TOG:  q[i] <= ~q[i];
                        default: q[i] <= q[i];
                    endcase
                end
            end
        end
    end

endmodule

// File: rtl/jk_bank_driver.sv
// Loads a target word into a JK register bank by deriving J/K commands,
// then reads the bank back, retrying up to RETRIES times before flagging err.
// Optional build macro: JK_TOGGLE_EN (toggle encoding for changing bits).
//
// Handshake: a target is transferred on a rising edge where tgt_valid and
// tgt_ready are both high; tgt_ready is high only in IDLE, and tgt_data is
// ignored at any other time. The source may hold tgt_valid high freely.
module jk_bank_driver
    import jk_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int RETRIES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tgt_valid,
    output logic             tgt_ready,
    input  logic [WIDTH-1:0] tgt_data,
    input  logic [WIDTH-1:0] frz,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] q,
    output logic             done,
    output logic             err,
    output logic [7:0]       upd_cnt,
    output logic [1:0]       state
);

    jk_drv_state_t    state_r;
    logic [WIDTH-1:0] tgt_q;
    logic [2:0]       retry_cnt;

    assign tgt_ready = (state_r == IDLE);
    assign state     = state_r;

    // J/K commands: excitation of q towards tgt_q, only while driving
    always_comb begin
        logic [1:0] code;
        code = JK_HOLD;
        j    = '0;
        k    = '0;
        if (state_r == DRIVE) begin
            for (int i = 0; i < WIDTH; i++) begin
                code = jk_excite(q[i], tgt_q[i]);
                j[i] = code[1];
                k[i] = code[0];
            end
        end
    end

    // Control FSM: accept, drive one cycle, check, retry or finish
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            tgt_q     <= '0;
            retry_cnt <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            upd_cnt   <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (tgt_valid) begin
                        tgt_q     <= tgt_data;
                        retry_cnt <= '0;
                        state_r   <= DRIVE;
                    end
                end
                DRIVE: begin
                    state_r <= CHECK;
                end
                CHECK: begin
                    if (q == tgt_q) begin
                        done <= 1'b1;
                        if (upd_cnt != 8'hFF) upd_cnt <= upd_cnt + 8'd1;
                        state_r <= IDLE;
                    end else if (int'(retry_cnt) < RETRIES) begin
                        retry_cnt <= retry_cnt + 3'd1;
                        state_r   <= DRIVE;
                    end else begin
                        err     <= 1'b1;
                        state_r <= IDLE;
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    jk_reg_bank #(.WIDTH(WIDTH)) u_bank (
        .clk   (clk),
        .rst_n (rst_n),
        .j     (j),
        .k     (k),
        .frz   (frz),
        .q     (q)
    );

endmodule

// File: tb/tb_jk_bank_driver.sv
// Directed bench for jk_bank_driver (WIDTH=4, RETRIES=2).
module tb_jk_bank_driver;
    import jk_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       tgt_valid;
    logic       tgt_ready;
    logic [3:0] tgt_data;
    logic [3:0] frz;
    logic [3:0] j;
    logic [3:0] k;
    logic [3:0] q;
    logic       done;
    logic       err;
    logic [7:0] upd_cnt;
    logic [1:0] state;

    int errors = 0;
    int checks = 0;

    logic [3:0] exp_q[$];

    int   cyc;
    int   drv;
    logic saw_done;
    logic saw_err;

    jk_bank_driver #(.WIDTH(4), .RETRIES(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tgt_valid (tgt_valid),
        .tgt_ready (tgt_ready),
        .tgt_data  (tgt_data),
        .frz       (frz),
        .j         (j),
        .k         (k),
        .q         (q),
        .done      (done),
        .err       (err),
        .upd_cnt   (upd_cnt),
        .state     (state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Call right after the accept edge; counts cycles until done/err (bounded).
    task automatic wait_result(output int cycles, output int drives,
                               output logic got_done, output logic got_err);
        cycles   = 0;
        drives   = 0;
        got_done = 1'b0;
        got_err  = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (state == DRIVE) drives++;
            tick();
            cycles++;
            if (done || err) begin
                got_done = done;
                got_err  = err;
                break;
            end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        tgt_valid = 1'b0;
        tgt_data  = 4'b0000;
        frz       = 4'b0000;
        #1;
        check("rst_q",     q,         0);
        check("rst_j",     j,         0);
        check("rst_k",     k,         0);
        check("rst_done",  done,      0);
        check("rst_err",   err,       0);
        check("rst_cnt",   upd_cnt,   0);
        check("rst_ready", tgt_ready, 1);
        check("rst_state", state,     IDLE);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // basic load 1010 from 0000
        tgt_valid = 1'b1;
        tgt_data  = 4'b1010;
        tick();
        tgt_valid = 1'b0;
        check("t1_ready_drive", tgt_ready, 0);
        check("t1_j", j, 4'b1010);
        check("t1_k", k, 4'b0000);
        tick();
        check("t1_check_q",    q,    4'b1010);
        check("t1_check_jk",   {j, k}, 8'h00);
        check("t1_check_done", done, 0);
        tick();
        check("t1_done",  done,      1);
        check("t1_err",   err,       0);
        check("t1_cnt",   upd_cnt,   1);
        check("t1_ready", tgt_ready, 1);
        tick();
        check("t1_done_pulse", done, 0);

        // 1010 -> 0110
        tgt_valid = 1'b1;
        tgt_data  = 4'b0110;
        tick();
        tgt_valid = 1'b0;
`ifdef JK_TOGGLE_EN
        check("t2_j", j, 4'b1100);
        check("t2_k", k, 4'b1100);
`else
        check("t2_j", j, 4'b0100);
        check("t2_k", k, 4'b1000);
`endif
        tick();
        tick();
        check("t2_done", done,    1);
        check("t2_q",    q,       4'b0110);
        check("t2_cnt",  upd_cnt, 2);

        // clear to 0000, then stuck bit 0 with retries exhausted
        tgt_valid = 1'b1;
        tgt_data  = 4'b0000;
        tick();
        tgt_valid = 1'b0;
        wait_result(cyc, drv, saw_done, saw_err);
        check("t3_clear_done", saw_done, 1);
        check("t3_clear_q",    q,        0);
        frz       = 4'b0001;
        tgt_valid = 1'b1;
        tgt_data  = 4'b0001;
        tick();
        tgt_valid = 1'b0;
        wait_result(cyc, drv, saw_done, saw_err);
        check("t3_err_cycles", cyc,      6);
        check("t3_drives",     drv,      3);
        check("t3_err",        saw_err,  1);
        check("t3_no_done",    saw_done, 0);
        check("t3_q",          q,        0);
        check("t3_cnt",        upd_cnt,  3);
        tick();
        check("t3_err_pulse", err, 0);

        // frozen for the first DRIVE only -> one retry
        frz       = 4'b0001;
        tgt_valid = 1'b1;
        tgt_data  = 4'b0001;
        tick();
        tgt_valid = 1'b0;
        tick();
        check("t4_first_q", q, 0);
        frz = 4'b0000;
        wait_result(cyc, drv, saw_done, saw_err);
        check("t4_cycles", cyc + 1,  4);
        check("t4_done",   saw_done, 1);
        check("t4_q",      q,        4'b0001);
        check("t4_cnt",    upd_cnt,  4);

        // tgt_valid held high; tgt_data garbage while busy
        tgt_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tgt_data = (i % 3 == 0) ? ((i % 6 == 0) ? 4'b0101 : 4'b1010) : 4'b1111;
            check("t5_ready", tgt_ready, (i % 3 == 0) ? 1 : 0);
            if (i > 0) check("t5_done", done, (i % 3 == 0) ? 1 : 0);
            if (i > 0 && i % 3 == 0) check("t5_q", q, exp_q.pop_front());
            if (i % 3 == 0) exp_q.push_back(tgt_data);
            tick();
        end
        tgt_valid = 1'b0;
        check("t5_last_done", done,    1);
        check("t5_last_q",    q,       exp_q.pop_front());
        check("t5_cnt",       upd_cnt, 7);

        // reset asserted during CHECK
        tgt_valid = 1'b1;
        tgt_data  = 4'b1111;
        tick();
        tgt_valid = 1'b0;
        tick();
        check("t6_in_check", state, CHECK);
        check("t6_q_set",    q,     4'b1111);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_q",     q,         0);
        check("t6_state", state,     IDLE);
        check("t6_ready", tgt_ready, 1);
        check("t6_cnt",   upd_cnt,   0);
        @(posedge clk);
        #1;
        check("t6_no_done", done, 0);
        check("t6_no_err",  err,  0);
        rst_n = 1'b1;
        tick();
        check("t6_post_done", {done, err}, 0);
        check("t6_post_q",    q,           0);

        // target equal to current q still runs and completes
        tgt_valid = 1'b1;
        tgt_data  = 4'b0000;
        tick();
        tgt_valid = 1'b0;
        check("t7_state", state, DRIVE);
        check("t7_jk",    {j, k}, 8'h00);
        wait_result(cyc, drv, saw_done, saw_err);
        check("t7_done",   saw_done, 1);
        check("t7_cycles", cyc,      2);
        check("t7_cnt",    upd_cnt,  1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
